monostable_scheduler: RTL and testbench



---
 rtl/monostable_sched_pkg.sv | 33 +++
 rtl/monostable_scheduler_rr_arbiter.sv | 31 +++
 rtl/monostable_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_monostable_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/monostable_sched_pkg.sv
// Shared types and sizing helpers for the monostable scheduler slice.
package monostable_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    ARM,
    TRIG,
    WAIT_HI,
    WAIT_LO,
    DONE,
    FAULT,
    GAP
  } state_t;

  localparam int STATE_W = 4;

  // One shared counter times TRIG, WAIT_HI/WAIT_LO and GAP, so it must hold the largest limit.
  function automatic int cnt_width(input int timeout_cycles, input int trig_cycles,
                                   input int gap_cycles);
    int m;
    m = timeout_cycles;
    if (trig_cycles > m) m = trig_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m + 1);
  endfunction

  // Width of the round-robin pointer; never collapses to zero bits.
  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/monostable_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the pointer wins.
module rr_arbiter
  import monostable_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan NUM_REQ slots starting at the pointer, wrapping modulo NUM_REQ, and keep the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/monostable_scheduler.sv
// Shares one retriggerable monostable between NUM_REQ requesters: arbitrates, sequences
// clear/arm/trigger on the chip pins and watches the synchronised Q for pulse start and end.
module monostable_scheduler
  import monostable_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TRIG_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout_err,
  output logic               busy,
  output logic               mono_a_n,
  output logic               mono_b,
  output logic               mono_r_n,
  input  logic               mono_q
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, TRIG_CYCLES, GAP_CYCLES);
  localparam int PTR_W = ptr_width(NUM_REQ);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TRIG_LIM = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [PTR_W-1:0]   ptr, ptr_nxt, win_idx, ptr_inc;
  logic [NUM_REQ-1:0] owner, owner_nxt;
  logic [NUM_REQ-1:0] arb_grant;
  logic               q_meta, q_s;
  logic               in_service;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arbiter (
    .req     (req),
    .pointer (ptr),
    .enable  (state == IDLE),
    .grant   (arb_grant)
  );

  // Two-flop synchroniser for the asynchronous Q output of the one-shot.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_meta <= 1'b0;
      q_s    <= 1'b0;
    end else begin
      q_meta <= mono_q;
      q_s    <= q_meta;
    end
  end

  // Encode the one-hot winner as an index and form the pointer that follows it.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) win_idx = PTR_W'(i);
    end
    ptr_inc = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
  end

  // Next-state logic; the shared counter restarts on every state change and saturates.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (|arb_grant) begin
          owner_nxt = arb_grant;
          ptr_nxt   = ptr_inc;
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        state_nxt = ARM;
      end
      ARM: begin
        cnt_nxt   = '0;
        state_nxt = TRIG;
      end
      TRIG: begin
        if (cnt_inc >= TRIG_LIM) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_HI;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_HI: begin
        if (q_s) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_LO;
        end else if (cnt_inc >= TO_LIM) begin
          cnt_nxt   = '0;
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_LO: begin
        if (!q_s) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else if (cnt_inc >= TO_LIM) begin
          cnt_nxt   = '0;
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DONE, FAULT: begin
        cnt_nxt   = '0;
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (cnt_inc >= GAP_LIM) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    in_service = state_nxt inside {CLEAR, ARM, TRIG, WAIT_HI, WAIT_LO};
  end

  // State, counter, pointer and owner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Registered outputs decoded from the next state so pins change cleanly with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      mono_a_n    <= 1'b1;
      mono_b      <= 1'b0;
      mono_r_n    <= 1'b0;
    end else begin
      grant       <= in_service ? owner_nxt : '0;
      done        <= (state_nxt == DONE) ? owner_nxt : '0;
      timeout_err <= (state_nxt == FAULT);
      busy        <= (state_nxt != IDLE);
      mono_a_n    <= 1'b0;
      mono_b      <= (state_nxt == TRIG);
      mono_r_n    <= !((state_nxt == CLEAR) || (state_nxt == FAULT));
    end
  end

endmodule

// File: tb/tb_monostable_scheduler.sv
// Scoreboard bench for monostable_scheduler with a behavioural retriggerable one-shot model.
module tb_monostable_scheduler;

  localparam int  NUM_REQ        = 4;
  localparam int  TRIG_CYCLES    = 2;
  localparam int  TIMEOUT_CYCLES = 64;
  localparam int  GAP_CYCLES     = 2;
  localparam int  HALF_PERIOD    = 10;
  localparam time PULSE_TIME     = 200;

  localparam int W_DONE   = 0;
  localparam int W_GRANT  = 1;
  localparam int W_B_HI   = 2;
  localparam int W_B_LO   = 3;
  localparam int W_TO     = 4;
  localparam int W_IDLE   = 5;

  typedef enum int {Q_NORMAL, Q_STUCK_LO, Q_STUCK_HI} q_mode_t;
  typedef struct {
    bit                 is_timeout;
    logic [NUM_REQ-1:0] vec;
  } exp_t;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req   = '0;
  logic [NUM_REQ-1:0] grant, done;
  logic               timeout_err, busy, mono_a_n, mono_b, mono_r_n;
  logic               mono_q = 1'b0;

  q_mode_t q_mode = Q_NORMAL;
  time     q_end  = 0;
  logic    b_prev = 1'b0;

  exp_t exp_q[$];
  exp_t exp_item;
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;

  logic [NUM_REQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  monostable_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .TRIG_CYCLES    (TRIG_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy),
    .mono_a_n    (mono_a_n),
    .mono_b      (mono_b),
    .mono_r_n    (mono_r_n),
    .mono_q      (mono_q)
  );

  // Free-running clock.
  always #HALF_PERIOD clk = ~clk;

  // One-shot model polled between clock edges: B rising with _A low fires, _R low clears.
  initial begin
    #1;
    forever begin
      if (mono_r_n !== 1'b1 && q_mode != Q_STUCK_HI) begin
        mono_q = 1'b0;
      end else if (mono_b === 1'b1 && b_prev !== 1'b1 && mono_a_n === 1'b0 &&
                   q_mode != Q_STUCK_LO) begin
        mono_q = 1'b1;
        q_end  = $time + PULSE_TIME;
      end else if (q_mode == Q_NORMAL && mono_q === 1'b1 && $time >= q_end) begin
        mono_q = 1'b0;
      end
      b_prev = mono_b;
      #2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic push_expect(input bit is_timeout, input logic [NUM_REQ-1:0] vec);
    exp_t e;
    e.is_timeout = is_timeout;
    e.vec        = vec;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input bit expect_out,
                               input bit is_timeout, input logic [NUM_REQ-1:0] done_vec);
    req = r;
    if (expect_out) push_expect(is_timeout, is_timeout ? '0 : done_vec);
  endtask

  function automatic bit cond_met(input int which);
    case (which)
      W_DONE:  return done !== '0;
      W_GRANT: return grant !== '0;
      W_B_HI:  return mono_b === 1'b1;
      W_B_LO:  return mono_b === 1'b0;
      W_TO:    return timeout_err === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string name,
                           output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (cond_met(which)) return;
      if (waited >= budget) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: still waiting after %0d cycles, required event", name, budget);
        return;
      end
    end
  endtask

  // Monitor: every done or timeout_err pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (reset === 1'b0 && (done !== '0 || timeout_err !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: got done=%b timeout_err=%b, required none",
                 done, timeout_err);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("scoreboard_done", 32'(done), 32'(exp_item.vec));
        checkOutput("scoreboard_timeout", 32'(timeout_err), 32'(exp_item.is_timeout));
      end
    end
  end

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    checkOutput("reset_r_n", 32'(mono_r_n), 32'(1'b0));
    checkOutput("reset_a_n", 32'(mono_a_n), 32'(1'b1));
    checkOutput("reset_b", 32'(mono_b), 32'(1'b0));
    checkOutput("reset_grant", 32'(grant), 32'(4'b0000));
    checkOutput("reset_busy", 32'(busy), 32'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_r_n", 32'(mono_r_n), 32'(1'b1));
    checkOutput("idle_a_n", 32'(mono_a_n), 32'(1'b0));
    checkOutput("idle_busy", 32'(busy), 32'(1'b0));

    // Single request, dropped mid-service
    $display("[TB] single request");
    applyStimulus(4'b0010, 1'b1, 1'b0, 4'b0010);
    @(negedge clk);
    checkOutput("clear_grant", 32'(grant), 32'(4'b0010));
    checkOutput("clear_busy", 32'(busy), 32'(1'b1));
    checkOutput("clear_r_n", 32'(mono_r_n), 32'(1'b0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    checkOutput("arm_b", 32'(mono_b), 32'(1'b0));
    checkOutput("arm_r_n", 32'(mono_r_n), 32'(1'b1));
    @(negedge clk);
    checkOutput("trig_b_first", 32'(mono_b), 32'(1'b1));
    @(negedge clk);
    checkOutput("trig_b_second", 32'(mono_b), 32'(1'b1));
    checkOutput("trig_grant_stable", 32'(grant), 32'(4'b0010));
    @(negedge clk);
    checkOutput("wait_hi_b", 32'(mono_b), 32'(1'b0));
    wait_cond(W_DONE, 100, "single_done_wait", cycles);
    checkOutput("done_grant_cleared", 32'(grant), 32'(4'b0000));
    repeat (2) @(negedge clk);
    checkOutput("gap_busy", 32'(busy), 32'(1'b1));
    @(negedge clk);
    checkOutput("after_gap_busy", 32'(busy), 32'(1'b0));

    // Round-robin from pointer 0
    $display("[TB] round robin");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0, rr_exp[0]);
    for (int i = 1; i < 5; i++) push_expect(1'b0, rr_exp[i]);
    for (int i = 0; i < 5; i++) begin
      wait_cond(W_GRANT, 20, "rr_grant_wait", cycles);
      checkOutput("rr_grant", 32'(grant), 32'(rr_exp[i]));
      wait_cond(W_DONE, 100, "rr_done_wait", cycles);
      if (i == 4) applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    end
    wait_cond(W_IDLE, 20, "rr_idle_wait", cycles);

    // Stuck-low Q: timeout in WAIT_HI, then normal service
    $display("[TB] stuck-low Q");
    q_mode = Q_STUCK_LO;
    applyStimulus(4'b0001, 1'b1, 1'b1, 4'b0000);
    wait_cond(W_B_HI, 10, "stuck_lo_b_rise", cycles);
    wait_cond(W_B_LO, 10, "stuck_lo_b_fall", cycles);
    wait_cond(W_TO, 200, "stuck_lo_timeout_wait", cycles);
    checkOutput("stuck_lo_latency", 32'(cycles), 32'(TIMEOUT_CYCLES));
    checkOutput("stuck_lo_r_n", 32'(mono_r_n), 32'(1'b0));
    checkOutput("stuck_lo_grant", 32'(grant), 32'(4'b0000));
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    q_mode = Q_NORMAL;
    wait_cond(W_IDLE, 20, "stuck_lo_idle_wait", cycles);
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001);
    wait_cond(W_DONE, 100, "recover_done_wait", cycles);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    wait_cond(W_IDLE, 20, "recover_idle_wait", cycles);

    // Stuck-high Q: timeout in WAIT_LO
    $display("[TB] stuck-high Q");
    q_mode = Q_STUCK_HI;
    applyStimulus(4'b0100, 1'b1, 1'b1, 4'b0000);
    wait_cond(W_B_HI, 10, "stuck_hi_b_rise", cycles);
    wait_cond(W_B_LO, 10, "stuck_hi_b_fall", cycles);
    wait_cond(W_TO, 200, "stuck_hi_timeout_wait", cycles);
    checkOutput("stuck_hi_latency", 32'(cycles), 32'(TIMEOUT_CYCLES + 1));
    checkOutput("stuck_hi_r_n", 32'(mono_r_n), 32'(1'b0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    q_mode = Q_NORMAL;
    wait_cond(W_IDLE, 20, "stuck_hi_idle_wait", cycles);
    repeat (2) @(negedge clk);

    // Reset during WAIT_LO, then re-grant from pointer 0
    $display("[TB] reset mid-pulse");
    applyStimulus(4'b0010, 1'b0, 1'b0, 4'b0000);
    wait_cond(W_B_HI, 10, "abort_b_rise", cycles);
    wait_cond(W_B_LO, 10, "abort_b_fall", cycles);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_grant", 32'(grant), 32'(4'b0000));
    checkOutput("abort_r_n", 32'(mono_r_n), 32'(1'b0));
    checkOutput("abort_done", 32'(done), 32'(4'b0000));
    checkOutput("abort_timeout", 32'(timeout_err), 32'(1'b0));
    checkOutput("abort_busy", 32'(busy), 32'(1'b0));
    applyStimulus(4'b0110, 1'b1, 1'b0, 4'b0010);
    reset = 1'b0;
    wait_cond(W_GRANT, 20, "regrant_wait", cycles);
    checkOutput("regrant_from_ptr0", 32'(grant), 32'(4'b0010));
    wait_cond(W_DONE, 100, "regrant_done_wait", cycles);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    wait_cond(W_IDLE, 20, "final_idle_wait", cycles);
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
